// File: rtl/blackhole_scene_sequencer_if.sv
// Control/status bundle between the VGA sync/renderer side and the scene sequencer.
// The sequencer takes the slave view; whoever drives vsync and the controls takes the master view.
interface blackhole_scene_sequencer_if;
    logic        vsync_in;
    logic        pause;
    logic        step;
    logic [1:0]  speed;
    logic        frame_tick;
    logic [15:0] frame_cnt;
    logic [1:0]  state_o;
    logic [9:0]  text_y;
    logic        text_en;
    logic [7:0]  ring_phase;

    modport slave (
        input  vsync_in, pause, step, speed,
        output frame_tick, frame_cnt, state_o, text_y, text_en, ring_phase
    );

    modport master (
        output vsync_in, pause, step, speed,
        input  frame_tick, frame_cnt, state_o, text_y, text_en, ring_phase
    );
endinterface

// File: rtl/blackhole_scene_sequencer.sv
// Frame-rate animation controller for the black-hole demo: detects frame boundaries on vsync
// and steps the text WAIT -> FALL -> SWALLOW cycle, updating outputs only at frame boundaries.
module blackhole_scene_sequencer #(
    parameter int TEXT_Y_TOP  = 20,
    parameter int SWALLOW_Y   = 200,
    parameter int WAIT_FRAMES = 128,
    parameter int HIDE_FRAMES = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    blackhole_scene_sequencer_if.slave     bus
);
    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_FALL    = 2'd1,
        ST_SWALLOW = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    localparam logic [9:0]  TOP_Y     = 10'(TEXT_Y_TOP);
    localparam logic [9:0]  SW_Y      = 10'(SWALLOW_Y);
    localparam logic [10:0] SW_Y_WIDE = 11'(SWALLOW_Y);
    localparam logic [8:0]  WAIT_LAST = 9'(WAIT_FRAMES - 1);
    localparam logic [8:0]  HIDE_LAST = 9'(HIDE_FRAMES - 1);

    state_t      state_r, state_nxt_s;
    logic        vsync_prev_r;
    logic        frame_tick_r;
    logic        pause_prev_r;
    logic        step_armed_r, step_armed_nxt_s;
    logic [15:0] frame_cnt_r;
    logic [7:0]  ring_phase_r;
    logic [9:0]  text_y_r, text_y_nxt_s;
    logic        text_en_r, text_en_nxt_s;
    logic [8:0]  dwell_r, dwell_nxt_s;
    logic [10:0] fall_sum_s;
    logic        adv_s;

    assign adv_s = frame_tick_r && (!bus.pause || step_armed_r);

    // Step arming: a new paused step wins over the clear so a step coincident with a tick arms the next one.
    always_comb begin
        step_armed_nxt_s = step_armed_r;
        if (bus.step && bus.pause) begin
            step_armed_nxt_s = 1'b1;
        end else if (adv_s) begin
            step_armed_nxt_s = 1'b0;
        end else if (pause_prev_r && !bus.pause) begin
            step_armed_nxt_s = 1'b0;
        end else begin
            step_armed_nxt_s = step_armed_r;
        end
    end

    // Next-state and next-output logic of the text-fall cycle, applied only on an advance.
    always_comb begin
        state_nxt_s   = state_r;
        text_y_nxt_s  = text_y_r;
        text_en_nxt_s = text_en_r;
        dwell_nxt_s   = dwell_r;
        fall_sum_s    = {1'b0, text_y_r} + (11'd1 << bus.speed);
        case (state_r)
            ST_WAIT: begin
                text_en_nxt_s = 1'b1;
                text_y_nxt_s  = TOP_Y;
                if (dwell_r == WAIT_LAST) begin
                    state_nxt_s = ST_FALL;
                    dwell_nxt_s = 9'd0;
                end else begin
                    dwell_nxt_s = dwell_r + 9'd1;
                end
            end
            ST_FALL: begin
                if (fall_sum_s >= SW_Y_WIDE) begin
                    text_y_nxt_s  = SW_Y;
                    text_en_nxt_s = 1'b0;
                    state_nxt_s   = ST_SWALLOW;
                    dwell_nxt_s   = 9'd0;
                end else begin
                    text_y_nxt_s  = fall_sum_s[9:0];
                end
            end
            ST_SWALLOW: begin
                text_en_nxt_s = 1'b0;
                if (dwell_r == HIDE_LAST) begin
                    state_nxt_s   = ST_WAIT;
                    text_y_nxt_s  = TOP_Y;
                    text_en_nxt_s = 1'b1;
                    dwell_nxt_s   = 9'd0;
                end else begin
                    dwell_nxt_s   = dwell_r + 9'd1;
                end
            end
            default: begin
                state_nxt_s   = ST_WAIT;
                text_y_nxt_s  = TOP_Y;
                text_en_nxt_s = 1'b1;
                dwell_nxt_s   = 9'd0;
            end
        endcase
    end

    // Frame boundary detection; vsync_prev resets high so releasing reset with vsync idle gives no tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_r <= 1'b1;
            frame_tick_r <= 1'b0;
            pause_prev_r <= 1'b0;
            step_armed_r <= 1'b0;
        end else begin
            vsync_prev_r <= bus.vsync_in;
            frame_tick_r <= !vsync_prev_r && bus.vsync_in;
            pause_prev_r <= bus.pause;
            step_armed_r <= step_armed_nxt_s;
        end
    end

    // Animation state and outputs, frozen except in the advance cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_WAIT;
            text_y_r     <= TOP_Y;
            text_en_r    <= 1'b1;
            dwell_r      <= 9'd0;
            frame_cnt_r  <= 16'd0;
            ring_phase_r <= 8'd0;
        end else if (adv_s) begin
            state_r      <= state_nxt_s;
            text_y_r     <= text_y_nxt_s;
            text_en_r    <= text_en_nxt_s;
            dwell_r      <= dwell_nxt_s;
            frame_cnt_r  <= frame_cnt_r + 16'd1;
            ring_phase_r <= ring_phase_r + 8'd1;
        end else begin
            state_r      <= state_r;
            text_y_r     <= text_y_r;
            text_en_r    <= text_en_r;
            dwell_r      <= dwell_r;
            frame_cnt_r  <= frame_cnt_r;
            ring_phase_r <= ring_phase_r;
        end
    end

    assign bus.frame_tick = frame_tick_r;
    assign bus.frame_cnt  = frame_cnt_r;
    assign bus.state_o    = state_r;
    assign bus.text_y     = text_y_r;
    assign bus.text_en    = text_en_r;
    assign bus.ring_phase = ring_phase_r;
endmodule

// File: tb/tb_blackhole_scene_sequencer.sv
// Directed self-checking bench for blackhole_scene_sequencer with default parameters.
module tb_blackhole_scene_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    blackhole_scene_sequencer_if bus ();

    blackhole_scene_sequencer #(
        .TEXT_Y_TOP(20), .SWALLOW_Y(200), .WAIT_FRAMES(128), .HIDE_FRAMES(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs {frame_cnt, state_o, text_y, text_en, ring_phase} for whole-snapshot comparisons.
    function automatic logic [36:0] snap();
        return {bus.frame_cnt, bus.state_o, bus.text_y, bus.text_en, bus.ring_phase};
    endfunction

    task automatic apply_reset();
        bus.vsync_in = 1'b1;
        bus.step     = 1'b0;
        bus.pause    = 1'b0;
        bus.speed    = 2'd0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One vsync low pulse; returns how many sampled cycles frame_tick was high afterwards.
    task automatic do_frame(output int width);
        @(negedge clk);
        bus.vsync_in = 1'b0;
        repeat (2) @(negedge clk);
        bus.vsync_in = 1'b1;
        width = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.frame_tick === 1'b1) width++;
        end
    endtask

    task automatic do_frames(input int n);
        int w;
        for (int i = 0; i < n; i++) do_frame(w);
    endtask

    task automatic step_pulse();
        @(negedge clk);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
    endtask

    task automatic test_reset();
        int ticks;
        apply_reset();
        n_cmp++;
        if (snap() !== {16'd0, 2'd0, 10'd20, 1'b1, 8'd0} || bus.frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: got %h tick %b want %h tick 0", snap(), bus.frame_tick,
                     {16'd0, 2'd0, 10'd20, 1'b1, 8'd0});
        end
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.frame_tick === 1'b1) ticks++;
        end
        n_cmp++;
        if (ticks !== 0) begin
            n_bad++;
            $display("FAIL idle_no_tick: got %0d ticks want 0", ticks);
        end
    endtask

    task automatic test_basic_ticks();
        int w;
        for (int i = 0; i < 3; i++) begin
            do_frame(w);
            n_cmp++;
            if (w !== 1) begin
                n_bad++;
                $display("FAIL tick_width[%0d]: got %0d cycles want 1", i, w);
            end
        end
        n_cmp++;
        if (snap() !== {16'd3, 2'd0, 10'd20, 1'b1, 8'd3}) begin
            n_bad++;
            $display("FAIL three_ticks: got %h want %h", snap(), {16'd3, 2'd0, 10'd20, 1'b1, 8'd3});
        end
    endtask

    task automatic test_full_cycle();
        apply_reset();
        do_frames(128);
        n_cmp++;
        if (snap() !== {16'd128, 2'd1, 10'd20, 1'b1, 8'd128}) begin
            n_bad++;
            $display("FAIL enter_fall: got %h want %h", snap(), {16'd128, 2'd1, 10'd20, 1'b1, 8'd128});
        end
        do_frames(1);
        n_cmp++;
        if (bus.text_y !== 10'd21) begin
            n_bad++;
            $display("FAIL fall_first_row: got %0d want 21", bus.text_y);
        end
        do_frames(178);
        n_cmp++;
        if (snap() !== {16'd307, 2'd1, 10'd199, 1'b1, 8'd51}) begin
            n_bad++;
            $display("FAIL fall_179: got %h want %h", snap(), {16'd307, 2'd1, 10'd199, 1'b1, 8'd51});
        end
        do_frames(1);
        n_cmp++;
        if (snap() !== {16'd308, 2'd2, 10'd200, 1'b0, 8'd52}) begin
            n_bad++;
            $display("FAIL swallow_entry: got %h want %h", snap(), {16'd308, 2'd2, 10'd200, 1'b0, 8'd52});
        end
        do_frames(31);
        n_cmp++;
        if (snap() !== {16'd339, 2'd2, 10'd200, 1'b0, 8'd83}) begin
            n_bad++;
            $display("FAIL swallow_31: got %h want %h", snap(), {16'd339, 2'd2, 10'd200, 1'b0, 8'd83});
        end
        do_frames(1);
        n_cmp++;
        if (snap() !== {16'd340, 2'd0, 10'd20, 1'b1, 8'd84}) begin
            n_bad++;
            $display("FAIL back_to_wait: got %h want %h", snap(), {16'd340, 2'd0, 10'd20, 1'b1, 8'd84});
        end
    endtask

    task automatic test_speed3();
        apply_reset();
        do_frames(128);
        bus.speed = 2'd3;
        do_frames(22);
        n_cmp++;
        if (bus.text_y !== 10'd196 || bus.state_o !== 2'd1) begin
            n_bad++;
            $display("FAIL speed3_22: got y=%0d st=%0d want y=196 st=1", bus.text_y, bus.state_o);
        end
        do_frames(1);
        n_cmp++;
        if (bus.text_y !== 10'd200 || bus.state_o !== 2'd2 || bus.text_en !== 1'b0) begin
            n_bad++;
            $display("FAIL speed3_saturate: got y=%0d st=%0d en=%b want y=200 st=2 en=0",
                     bus.text_y, bus.state_o, bus.text_en);
        end
    endtask

    task automatic test_pause_step();
        int w;
        apply_reset();
        do_frames(128);
        do_frames(30);
        n_cmp++;
        if (snap() !== {16'd158, 2'd1, 10'd50, 1'b1, 8'd158}) begin
            n_bad++;
            $display("FAIL pre_pause: got %h want %h", snap(), {16'd158, 2'd1, 10'd50, 1'b1, 8'd158});
        end
        bus.pause = 1'b1;
        for (int i = 0; i < 5; i++) do_frame(w);
        n_cmp++;
        if (w !== 1) begin
            n_bad++;
            $display("FAIL paused_tick: got %0d cycles want 1", w);
        end
        n_cmp++;
        if (snap() !== {16'd158, 2'd1, 10'd50, 1'b1, 8'd158}) begin
            n_bad++;
            $display("FAIL paused_frozen: got %h want %h", snap(), {16'd158, 2'd1, 10'd50, 1'b1, 8'd158});
        end
        step_pulse();
        step_pulse();
        do_frames(1);
        n_cmp++;
        if (snap() !== {16'd159, 2'd1, 10'd51, 1'b1, 8'd159}) begin
            n_bad++;
            $display("FAIL step_advance: got %h want %h", snap(), {16'd159, 2'd1, 10'd51, 1'b1, 8'd159});
        end
        do_frames(1);
        n_cmp++;
        if (snap() !== {16'd159, 2'd1, 10'd51, 1'b1, 8'd159}) begin
            n_bad++;
            $display("FAIL step_once: got %h want %h", snap(), {16'd159, 2'd1, 10'd51, 1'b1, 8'd159});
        end
    endtask

    task automatic test_step_unpaused();
        @(negedge clk);
        bus.pause = 1'b0;
        step_pulse();
        @(negedge clk);
        bus.pause = 1'b1;
        do_frames(1);
        n_cmp++;
        if (snap() !== {16'd159, 2'd1, 10'd51, 1'b1, 8'd159}) begin
            n_bad++;
            $display("FAIL unpaused_step_ignored: got %h want %h", snap(), {16'd159, 2'd1, 10'd51, 1'b1, 8'd159});
        end
        bus.pause = 1'b0;
        do_frames(1);
        n_cmp++;
        if (snap() !== {16'd160, 2'd1, 10'd52, 1'b1, 8'd160}) begin
            n_bad++;
            $display("FAIL resume: got %h want %h", snap(), {16'd160, 2'd1, 10'd52, 1'b1, 8'd160});
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        do_frames(128);
        do_frames(100);
        n_cmp++;
        if (bus.text_y !== 10'd120 || bus.state_o !== 2'd1) begin
            n_bad++;
            $display("FAIL pre_async: got y=%0d st=%0d want y=120 st=1", bus.text_y, bus.state_o);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (snap() !== {16'd0, 2'd0, 10'd20, 1'b1, 8'd0} || bus.frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got %h want %h", snap(), {16'd0, 2'd0, 10'd20, 1'b1, 8'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_frames(127);
        n_cmp++;
        if (snap() !== {16'd127, 2'd0, 10'd20, 1'b1, 8'd127}) begin
            n_bad++;
            $display("FAIL post_reset_127: got %h want %h", snap(), {16'd127, 2'd0, 10'd20, 1'b1, 8'd127});
        end
        do_frames(1);
        n_cmp++;
        if (bus.state_o !== 2'd1) begin
            n_bad++;
            $display("FAIL post_reset_fall: got st=%0d want 1", bus.state_o);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic_ticks();
        test_full_cycle();
        test_speed3();
        test_pause_step();
        test_step_unpaused();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
